// File: rtl/mdu_issue_seq.sv
// mdu_issue_seq: sequencer between execute and the multiply/divide unit.
// Accepts one RV32M op at a time, holds the MDU operands stable, stalls the
// pipeline while the op is in flight and emits a one-cycle writeback.
// A flush never aborts the MDU; an in-flight op is drained and discarded.
// Optional single-entry divide result cache: define MDU_RESULT_CACHE_EN.
module mdu_issue_seq #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_valid,
   input  logic [2:0]       issue_op,
   input  logic [31:0]      issue_src1,
   input  logic [31:0]      issue_src2,
   input  logic [4:0]       issue_rd,
   input  logic             flush,
   output logic             stall,
   output logic             mdu_req_valid,
   output logic             mdu_res_ack,
   output logic [31:0]      mdu_src1,
   output logic [31:0]      mdu_src2,
   output logic [2:0]       mdu_op,
   input  logic             mdu_res_valid,
   input  logic [31:0]      mdu_result,
   output logic             wb_valid,
   output logic [4:0]       wb_rd,
   output logic [31:0]      wb_data,
   output logic [CNT_W-1:0] busy_cycles
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDrain} state_t;

   state_t           state_q, state_d;
   logic [31:0]      src1_q, src2_q;
   logic [2:0]       op_q;
   logic [4:0]       rd_q;
   logic             wb_valid_q;
   logic [4:0]       wb_rd_q, wb_rd_d;
   logic [31:0]      wb_data_q, wb_data_d;
   logic [CNT_W-1:0] busy_q;

   logic             accept;
   logic             wb_set;
   logic             hit;
   logic [31:0]      hit_data;

`ifdef MDU_RESULT_CACHE_EN
   logic             c_vld_q;
   logic [2:0]       c_op_q;
   logic [31:0]      c_src1_q, c_src2_q, c_res_q;
   logic             cache_wr;

   // Only div-class ops (funct3[2]) are cached; MUL ops always use the MDU.
   assign hit      = issue_op[2] && c_vld_q && (c_op_q == issue_op) &&
                     (c_src1_q == issue_src1) && (c_src2_q == issue_src2);
   assign hit_data = c_res_q;
   assign cache_wr = (state_q == StWait) && mdu_res_valid && !flush && op_q[2];

   // Cache entry: refilled on every non-flushed divide writeback, cleared by reset only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_vld_q  <= 1'b0;
         c_op_q   <= 3'd0;
         c_src1_q <= 32'd0;
         c_src2_q <= 32'd0;
         c_res_q  <= 32'd0;
      end else if (cache_wr) begin
         c_vld_q  <= 1'b1;
         c_op_q   <= op_q;
         c_src1_q <= src1_q;
         c_src2_q <= src2_q;
         c_res_q  <= mdu_result;
      end
   end
`else
   assign hit      = 1'b0;
   assign hit_data = 32'd0;
`endif

   // Next-state, handshake and writeback selection.
   always_comb begin
      state_d       = state_q;
      stall         = 1'b0;
      mdu_req_valid = 1'b0;
      mdu_res_ack   = 1'b0;
      accept        = 1'b0;
      wb_set        = 1'b0;
      wb_data_d     = wb_data_q;
      wb_rd_d       = wb_rd_q;
      unique case (state_q)
         StIdle: begin
            if (issue_valid && !flush) begin
               stall = 1'b1;
               if (hit) begin
                  // Hold a hit back one cycle if a writeback is already going out,
                  // so wb_valid never fires on two consecutive cycles.
                  if (!wb_valid_q) begin
                     accept    = 1'b1;
                     wb_set    = 1'b1;
                     wb_data_d = hit_data;
                     wb_rd_d   = issue_rd;
                  end
               end else begin
                  accept  = 1'b1;
                  state_d = StReq;
               end
            end
         end
         StReq: begin
            stall = 1'b1;
            if (flush) begin
               // MDU never saw the request, so nothing needs draining.
               state_d = StIdle;
            end else begin
               mdu_req_valid = 1'b1;
               state_d       = StWait;
            end
         end
         StWait: begin
            stall = 1'b1;
            if (mdu_res_valid) begin
               mdu_res_ack = 1'b1;
               state_d     = StIdle;
               if (!flush) begin
                  wb_set    = 1'b1;
                  wb_data_d = mdu_result;
                  wb_rd_d   = rd_q;
               end
            end else if (flush) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            stall = 1'b1;
            if (mdu_res_valid) begin
               mdu_res_ack = 1'b1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand latch: MDU inputs change only when an instruction is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src1_q <= 32'd0;
         src2_q <= 32'd0;
         op_q   <= 3'd0;
         rd_q   <= 5'd0;
      end else if (accept) begin
         src1_q <= issue_src1;
         src2_q <= issue_src2;
         op_q   <= issue_op;
         rd_q   <= issue_rd;
      end
   end

   // Writeback register: one-cycle strobe with data held afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid_q <= 1'b0;
         wb_rd_q    <= 5'd0;
         wb_data_q  <= 32'd0;
      end else begin
         wb_valid_q <= wb_set;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
      end
   end

   // Busy-cycle counter, wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
      end else if (stall) begin
         busy_q <= busy_q + CNT_W'(1);
      end
   end

   assign mdu_src1    = src1_q;
   assign mdu_src2    = src2_q;
   assign mdu_op      = op_q;
   assign wb_valid    = wb_valid_q;
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;
   assign busy_cycles = busy_q;

endmodule

// File: tb/tb_mdu_issue_seq.sv
// Bench for mdu_issue_seq: behavioural MDU responder plus a reference model of
// the RV32M results and the issue/writeback timeline. Inputs change and outputs
// are sampled on the falling edge.
module tb_mdu_issue_seq;

   logic        clk;
   logic        rst;
   logic        issue_valid;
   logic [2:0]  issue_op;
   logic [31:0] issue_src1;
   logic [31:0] issue_src2;
   logic [4:0]  issue_rd;
   logic        flush;
   logic        stall;
   logic        mdu_req_valid;
   logic        mdu_res_ack;
   logic [31:0] mdu_src1;
   logic [31:0] mdu_src2;
   logic [2:0]  mdu_op;
   logic        mdu_res_valid;
   logic [31:0] mdu_result;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [31:0] busy_cycles;

   int compared;
   int mismatched;
   longint busy_model;

`ifdef MDU_RESULT_CACHE_EN
   bit          c_vld;
   logic [2:0]  c_op;
   logic [31:0] c_a, c_b, c_res;
`endif

   mdu_issue_seq #(.CNT_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .issue_valid  (issue_valid),
      .issue_op     (issue_op),
      .issue_src1   (issue_src1),
      .issue_src2   (issue_src2),
      .issue_rd     (issue_rd),
      .flush        (flush),
      .stall        (stall),
      .mdu_req_valid(mdu_req_valid),
      .mdu_res_ack  (mdu_res_ack),
      .mdu_src1     (mdu_src1),
      .mdu_src2     (mdu_src2),
      .mdu_op       (mdu_op),
      .mdu_res_valid(mdu_res_valid),
      .mdu_result   (mdu_result),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .busy_cycles  (busy_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RV32M result from the ISA rules.
   function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      bit ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = longint'({32'd0, a});
      ub  = longint'({32'd0, b});
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = 64'd0;
      case (op)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            p = sa / sb;
            return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            p = sa % sb;
            return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   // Cycles from acceptance to writeback.
   function automatic int lat_of(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
      if (!op[2]) return 3;
      if (b == 0) return 4;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 4;
      return 35;
   endfunction

   // Behavioural MDU: result valid (lat-2) cycles after the request, held until acked.
   int mdu_cnt;
   bit mdu_pend;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mdu_res_valid <= 1'b0;
         mdu_result    <= 32'd0;
         mdu_pend      <= 1'b0;
         mdu_cnt       <= 0;
      end else begin
         if (mdu_res_valid && mdu_res_ack) mdu_res_valid <= 1'b0;
         if (mdu_req_valid) begin
            mdu_result <= ref_result(mdu_op, mdu_src1, mdu_src2);
            if (lat_of(mdu_op, mdu_src1, mdu_src2) - 2 == 1) begin
               mdu_res_valid <= 1'b1;
               mdu_pend      <= 1'b0;
            end else begin
               mdu_pend <= 1'b1;
               mdu_cnt  <= lat_of(mdu_op, mdu_src1, mdu_src2) - 3;
            end
         end else if (mdu_pend) begin
            if (mdu_cnt == 1) begin
               mdu_res_valid <= 1'b1;
               mdu_pend      <= 1'b0;
            end else begin
               mdu_cnt <= mdu_cnt - 1;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one instruction and check every cycle of its timeline.
   // f: cycle (relative to issue) at which flush is pulsed, -1 for none.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int f);
      int lat;
      bit hit;
      bit e_stall, e_req, e_ack, e_wb;
      logic [31:0] res;
      lat = lat_of(op, a, b);
      res = ref_result(op, a, b);
      hit = 1'b0;
`ifdef MDU_RESULT_CACHE_EN
      if (op[2] && c_vld && c_op == op && c_a == a && c_b == b) begin
         hit = 1'b1;
         res = c_res;
         lat = 1;
      end
`endif
      for (int c = 0; c <= lat + 1; c++) begin
         @(negedge clk);
         issue_valid = (c == 0);
         issue_op    = op;
         issue_src1  = a;
         issue_src2  = b;
         issue_rd    = rd;
         flush       = (c == f);
         #1;
         e_req = 1'b0;
         e_ack = 1'b0;
         e_wb  = 1'b0;
         if (f == 0) begin
            e_stall = 1'b0;
         end else if (hit) begin
            e_stall = (c == 0);
            e_wb    = (c == 1);
         end else if (f == 1) begin
            e_stall = (c <= 1);
         end else begin
            e_stall = (c <= lat - 1);
            e_req   = (c == 1);
            e_ack   = (c == lat - 1);
            e_wb    = (c == lat) && (f < 0);
         end
         busy_model += longint'(e_stall);
         check($sformatf("stall op%0d c%0d", op, c), 64'(stall), 64'(e_stall));
         check($sformatf("req op%0d c%0d", op, c), 64'(mdu_req_valid), 64'(e_req));
         check($sformatf("ack op%0d c%0d", op, c), 64'(mdu_res_ack), 64'(e_ack));
         check($sformatf("wb_valid op%0d c%0d", op, c), 64'(wb_valid), 64'(e_wb));
         if (e_wb) begin
            check($sformatf("wb_data op%0d a=%0h b=%0h", op, a, b), 64'(wb_data), 64'(res));
            check($sformatf("wb_rd op%0d", op), 64'(wb_rd), 64'(rd));
         end
         if (c == 1 && f != 0 && !hit) begin
            check("mdu_src1", 64'(mdu_src1), 64'(a));
            check("mdu_src2", 64'(mdu_src2), 64'(b));
            check("mdu_op", 64'(mdu_op), 64'(op));
         end
      end
      check($sformatf("busy_cycles after op%0d", op), 64'(busy_cycles),
            64'(busy_model[31:0]));
`ifdef MDU_RESULT_CACHE_EN
      if (op[2] && !hit && f < 0) begin
         c_vld = 1'b1;
         c_op  = op;
         c_a   = a;
         c_b   = b;
         c_res = res;
      end
`endif
   endtask

   logic [2:0]  r_op, last_op;
   logic [31:0] r_a, r_b, last_a, last_b;
   int          sel, r_f;

   initial begin
      compared    = 0;
      mismatched  = 0;
      busy_model  = 0;
      rst         = 1'b1;
      issue_valid = 1'b0;
      issue_op    = 3'd0;
      issue_src1  = 32'd0;
      issue_src2  = 32'd0;
      issue_rd    = 5'd0;
      flush       = 1'b0;
      last_op     = 3'd5;
      last_a      = 32'd100;
      last_b      = 32'd7;
`ifdef MDU_RESULT_CACHE_EN
      c_vld = 1'b0;
      c_op  = 3'd0;
      c_a   = 32'd0;
      c_b   = 32'd0;
      c_res = 32'd0;
`endif
      repeat (3) @(negedge clk);
      #1;
      check("reset stall", 64'(stall), 64'd0);
      check("reset req", 64'(mdu_req_valid), 64'd0);
      check("reset wb_valid", 64'(wb_valid), 64'd0);
      check("reset busy", 64'(busy_cycles), 64'd0);
      check("reset src1", 64'(mdu_src1), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed cases.
      do_op(3'd0, 32'd7, 32'd6, 5'd3, -1);
      do_op(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd5, -1);
      do_op(3'd6, 32'hFFFF_FF9C, 32'd7, 5'd5, -1);
      do_op(3'd5, 32'h0000_1234, 32'd0, 5'd9, -1);
      do_op(3'd7, 32'h0000_1234, 32'd0, 5'd9, -1);
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, -1);
      do_op(3'd4, 32'd1000, 32'd3, 5'd4, 10);
      do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 5'd6, 1);
      do_op(3'd0, 32'd5, 32'd5, 5'd7, 0);
      do_op(3'd5, 32'd100, 32'd7, 5'd8, -1);
      do_op(3'd5, 32'd100, 32'd7, 5'd8, -1);
      do_op(3'd5, 32'd100, 32'd8, 5'd8, -1);

      // Asynchronous reset in the middle of a divide.
      @(negedge clk);
      issue_valid = 1'b1;
      issue_op    = 3'd4;
      issue_src1  = 32'd1000;
      issue_src2  = 32'd3;
      issue_rd    = 5'd2;
      flush       = 1'b0;
      @(negedge clk);
      issue_valid = 1'b0;
      repeat (19) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mid-op reset stall", 64'(stall), 64'd0);
      check("mid-op reset req", 64'(mdu_req_valid), 64'd0);
      check("mid-op reset ack", 64'(mdu_res_ack), 64'd0);
      check("mid-op reset wb_valid", 64'(wb_valid), 64'd0);
      check("mid-op reset busy", 64'(busy_cycles), 64'd0);
      check("mid-op reset op", 64'(mdu_op), 64'd0);
      check("mid-op reset src1", 64'(mdu_src1), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      busy_model = 0;
`ifdef MDU_RESULT_CACHE_EN
      c_vld = 1'b0;
`endif
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         #1;
         check($sformatf("post-reset idle wb c%0d", c), 64'(wb_valid), 64'd0);
         check($sformatf("post-reset idle stall c%0d", c), 64'(stall), 64'd0);
      end
      do_op(3'd0, 32'd7, 32'd6, 5'd11, -1);

      // Randomised traffic.
      for (int n = 0; n < 40; n++) begin
         r_op = 3'($urandom_range(0, 7));
         sel  = $urandom_range(0, 5);
         case (sel)
            0: begin r_a = $urandom; r_b = 32'd0; end
            1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
            2: begin r_a = 32'($urandom_range(0, 300)); r_b = 32'($urandom_range(1, 20)); end
            default: begin r_a = $urandom; r_b = $urandom; end
         endcase
         if ($urandom_range(0, 3) == 0) begin
            r_op = last_op;
            r_a  = last_a;
            r_b  = last_b;
         end
         if ($urandom_range(0, 3) == 0) r_f = $urandom_range(0, lat_of(r_op, r_a, r_b) - 1);
         else r_f = -1;
         do_op(r_op, r_a, r_b, 5'($urandom_range(0, 31)), r_f);
         if (r_op[2]) begin
            last_op = r_op;
            last_a  = r_a;
            last_b  = r_b;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
